// File: rtl/soc_system_pio_in_irq_if.sv
// Avalon-MM slave bus bundle for the interrupt-capable input PIO.
//   address    - word address of the register being accessed
//   chipselect - slave select
//   write_n    - active-low write strobe
//   writedata  - write data
//   readdata   - registered read data returned by the slave
// The master modport belongs to the bridge/testbench side and the slave
// modport to the PIO.
interface soc_system_pio_in_irq_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/soc_system_pio_in_irq.sv
// Interrupt-capable input PIO on the HPS lightweight bridge.
// Samples an asynchronous WIDTH-bit input bus (switches/keys) through a
// synchroniser, debounces every bit independently, captures edges of the
// debounced value and raises a maskable level interrupt.
//
// Ports:
//   clk      - system clock, all state on posedge
//   reset_n  - asynchronous active-low reset, clears all state
//   bus      - Avalon-MM slave (address, chipselect, write_n, writedata,
//              readdata); one-cycle registered read latency
//   in_port  - asynchronous external inputs
//   irq      - registered active-high level interrupt
//
// Register map (word addresses):
//   0 DATA        debounced value, read-only
//   1 RAW         synchronised value before debounce, read-only
//   2 IRQMASK     read/write, WIDTH bits
//   3 EDGECAPTURE write-1-to-clear
module soc_system_pio_in_irq #(
    parameter int WIDTH           = 10,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int EDGE_TYPE       = 0
) (
    input  logic                      clk,
    input  logic                      reset_n,
    soc_system_pio_in_irq_if.slave    bus,
    input  logic [WIDTH-1:0]          in_port,
    output logic                      irq
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    // Zero-extend a WIDTH-bit register onto the 32-bit read bus.
    function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
        logic [31:0] r;
        r = '0;
        r[WIDTH-1:0] = v;
        return r;
    endfunction

    // Whether a debounced bit settling on new value nv counts as a captured
    // edge. The bit only updates when it differs from its old value, so the
    // new value alone identifies the direction.
    function automatic logic edge_hit(input logic nv);
        case (EDGE_TYPE)
            0:       return nv;
            1:       return ~nv;
            default: return 1'b1;
        endcase
    endfunction

    logic [WIDTH-1:0] sync_p [SYNC_STAGES];
    logic [WIDTH-1:0] raw;

    logic [WIDTH-1:0] deb_q, deb_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [WIDTH-1:0] edge_evt;

    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] ecap_q, ecap_d;
    logic [WIDTH-1:0] clr_bits;
    logic             wr_en;
    logic             irq_d;
    logic [31:0]      rd_d;

    // writedata bits above WIDTH carry no meaning for any register.
    logic             unused_wdata;
    assign unused_wdata = ^bus.writedata;

    // ---- stage: synchroniser chain (in_port -> raw) ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_p[i] <= '0;
            end
        end else begin
            sync_p[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_p[i] <= sync_p[i-1];
            end
        end
    end

    assign raw = sync_p[SYNC_STAGES-1];

    // ---- stage: per-bit debounce (raw -> deb) and edge detection ----
    // The counter only runs while raw disagrees with the debounced value and
    // restarts from zero whenever they agree, so a glitch shorter than
    // DEBOUNCE_CYCLES never reaches deb.
    always_comb begin
        deb_d    = deb_q;
        edge_evt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (raw[i] == deb_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                deb_d[i]    = raw[i];
                cnt_d[i]    = '0;
                edge_evt[i] = edge_hit(raw[i]);
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
        end
    end

    // ---- stage: register file and interrupt ----
    always_comb begin
        wr_en    = bus.chipselect & ~bus.write_n;
        mask_d   = mask_q;
        clr_bits = '0;
        if (wr_en && bus.address == 2'd2) begin
            mask_d = bus.writedata[WIDTH-1:0];
        end
        if (wr_en && bus.address == 2'd3) begin
            clr_bits = bus.writedata[WIDTH-1:0];
        end
        // A new edge on the same clock as its clear keeps the bit set.
        ecap_d = (ecap_q & ~clr_bits) | edge_evt;
        irq_d  = |(ecap_d & mask_d);

        // Read mux samples the register values as they stand before this
        // edge, independent of chipselect.
        case (bus.address)
            2'd0:    rd_d = zext(deb_q);
            2'd1:    rd_d = zext(raw);
            2'd2:    rd_d = zext(mask_q);
            default: rd_d = zext(ecap_q);
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            deb_q        <= '0;
            mask_q       <= '0;
            ecap_q       <= '0;
            irq          <= 1'b0;
            bus.readdata <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            deb_q        <= deb_d;
            mask_q       <= mask_d;
            ecap_q       <= ecap_d;
            irq          <= irq_d;
            bus.readdata <= rd_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

endmodule
